// File: rtl/ahb_resp_mux.sv
// Per-master AHB response multiplexer: holds the address-phase slave select through the data phase,
// and adds a default-slave ERROR for bad selects plus a stall watchdog that aborts hung transfers.
//
// state    | meaning
// D_IDLE   | no data phase in progress (IDLE/BUSY or after reset), OKAY with ready high
// D_SLAVE  | data phase owned by the slave in hsel_data, responses passed straight through
// DEF_ERR1 | default-slave ERROR, first cycle (ready low)
// DEF_ERR2 | default-slave ERROR, second cycle (ready high)
// TO_ERR1  | watchdog abort ERROR, first cycle (ready low, timeout_irq high)
// TO_ERR2  | watchdog abort ERROR, second cycle (ready high)
module ahb_resp_mux #(
    parameter int CHANNEL_NUM = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int RESP_WIDTH  = 1,
    parameter int TIMEOUT     = 256,
    parameter int CNT_WIDTH   = 9
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [CHANNEL_NUM-1:0]            sel_addr,
    input  logic [1:0]                        htrans,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] hrdata_in,
    input  logic [CHANNEL_NUM-1:0]            hreadyout_in,
    input  logic [CHANNEL_NUM*RESP_WIDTH-1:0] hresp_in,
    output logic [DATA_WIDTH-1:0]             hrdata_out,
    output logic                              hready_out,
    output logic [RESP_WIDTH-1:0]             hresp_out,
    output logic [CHANNEL_NUM-1:0]            hsel_data,
    output logic                              timeout_irq
);

    typedef enum logic [2:0] {
        D_IDLE,
        D_SLAVE,
        DEF_ERR1,
        DEF_ERR2,
        TO_ERR1,
        TO_ERR2
    } state_t;

    localparam bit                   WD_EN    = (TIMEOUT > 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = WD_EN ? CNT_WIDTH'(TIMEOUT - 1) : '0;
    localparam logic [RESP_WIDTH-1:0] RESP_ERR = RESP_WIDTH'(1);

    state_t                 state, state_nxt;
    logic [CHANNEL_NUM-1:0] hsel_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic                   irq_nxt;

    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   sel_ready;
    logic [RESP_WIDTH-1:0]  sel_resp;

    // Only the transfer/no-transfer distinction matters here; BUSY is treated like IDLE.
    logic unused_htrans;
    assign unused_htrans = htrans[0];

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_resp  = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (hsel_data[i]) begin
                sel_rdata |= hrdata_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ready |= hreadyout_in[i];
                sel_resp  |= hresp_in[i*RESP_WIDTH +: RESP_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        hsel_nxt   = hsel_data;
        cnt_nxt    = '0;
        irq_nxt    = 1'b0;
        hready_out = 1'b1;
        hresp_out  = '0;
        hrdata_out = '0;

        case (state)
            D_IDLE: ;
            D_SLAVE: begin
                hready_out = sel_ready;
                hresp_out  = sel_resp;
                hrdata_out = sel_rdata;
                if (WD_EN && !sel_ready) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = TO_ERR1;
                        hsel_nxt  = '0;
                        irq_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_WIDTH'(1);
                    end
                end
            end
            DEF_ERR1: begin
                hready_out = 1'b0;
                hresp_out  = RESP_ERR;
                state_nxt  = DEF_ERR2;
            end
            DEF_ERR2: hresp_out = RESP_ERR;
            TO_ERR1: begin
                hready_out = 1'b0;
                hresp_out  = RESP_ERR;
                state_nxt  = TO_ERR2;
            end
            TO_ERR2: hresp_out = RESP_ERR;
            default: begin
                state_nxt = D_IDLE;
                hsel_nxt  = '0;
            end
        endcase

        // Address acceptance overrides everything; it cannot happen in the ERR1 states.
        if (hready_out) begin
            cnt_nxt = '0;
            irq_nxt = 1'b0;
            if (!htrans[1]) begin
                state_nxt = D_IDLE;
                hsel_nxt  = '0;
            end else if ($onehot(sel_addr)) begin
                state_nxt = D_SLAVE;
                hsel_nxt  = sel_addr;
            end else begin
                state_nxt = DEF_ERR1;
                hsel_nxt  = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= D_IDLE;
            hsel_data   <= '0;
            cnt         <= '0;
            timeout_irq <= 1'b0;
        end else begin
            state       <= state_nxt;
            hsel_data   <= hsel_nxt;
            cnt         <= cnt_nxt;
            timeout_irq <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux: a watchdog instance (TIMEOUT=8) and a disabled-watchdog instance (TIMEOUT=0)
// share stimulus; both are compared every cycle against a transaction-level reference model.
module tb_ahb_resp_mux;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int RW = 1;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [CH-1:0]     sel_addr;
    logic [1:0]        htrans;
    logic [CH*DW-1:0]  hrdata_in;
    logic [CH-1:0]     hreadyout_in;
    logic [CH*RW-1:0]  hresp_in;

    logic [DW-1:0] a_hrdata_out, b_hrdata_out;
    logic          a_hready_out, b_hready_out;
    logic [RW-1:0] a_hresp_out, b_hresp_out;
    logic [CH-1:0] a_hsel_data, b_hsel_data;
    logic          a_timeout_irq, b_timeout_irq;

    ahb_resp_mux #(.CHANNEL_NUM(CH), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .TIMEOUT(8), .CNT_WIDTH(4)) dut_wd (
        .HCLK(HCLK), .HRESETn(HRESETn), .sel_addr(sel_addr), .htrans(htrans),
        .hrdata_in(hrdata_in), .hreadyout_in(hreadyout_in), .hresp_in(hresp_in),
        .hrdata_out(a_hrdata_out), .hready_out(a_hready_out), .hresp_out(a_hresp_out),
        .hsel_data(a_hsel_data), .timeout_irq(a_timeout_irq));

    ahb_resp_mux #(.CHANNEL_NUM(CH), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .TIMEOUT(0), .CNT_WIDTH(4)) dut_nowd (
        .HCLK(HCLK), .HRESETn(HRESETn), .sel_addr(sel_addr), .htrans(htrans),
        .hrdata_in(hrdata_in), .hreadyout_in(hreadyout_in), .hresp_in(hresp_in),
        .hrdata_out(b_hrdata_out), .hready_out(b_hready_out), .hresp_out(b_hresp_out),
        .hsel_data(b_hsel_data), .timeout_irq(b_timeout_irq));

    always #5 HCLK = ~HCLK;

    // Reference: which slave owns the data phase (-1 none), error cycles still to
    // deliver (2 = ready-low cycle pending), stall cycles seen so far, irq this cycle.
    typedef struct {
        int slv;
        int err_left;
        int stall;
        bit irq;
    } mdl_t;

    localparam mdl_t MDL_RST = '{slv: -1, err_left: 0, stall: 0, irq: 1'b0};

    mdl_t ma, mb;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void mdl_out(input mdl_t m, output logic rdy, output logic [RW-1:0] rsp,
                                    output logic [DW-1:0] dat, output logic [CH-1:0] sel);
        rdy = 1'b1;
        rsp = '0;
        dat = '0;
        sel = '0;
        if (m.err_left == 2) begin
            rdy = 1'b0;
            rsp = RW'(1);
        end else if (m.err_left == 1) begin
            rsp = RW'(1);
        end else if (m.slv >= 0) begin
            rdy      = hreadyout_in[m.slv];
            rsp      = hresp_in[m.slv*RW +: RW];
            dat      = hrdata_in[m.slv*DW +: DW];
            sel[m.slv] = 1'b1;
        end
    endfunction

    task automatic mdl_step(inout mdl_t m, input int tmo);
        logic          rdy;
        logic [RW-1:0] r;
        logic [DW-1:0] d;
        logic [CH-1:0] s;
        mdl_out(m, rdy, r, d, s);
        m.irq = 1'b0;
        if (m.err_left == 2) begin
            m.err_left = 1;
        end else if (rdy) begin
            m.err_left = 0;
            m.stall    = 0;
            m.slv      = -1;
            if (htrans[1]) begin
                if ($countones(sel_addr) == 1) begin
                    for (int i = 0; i < CH; i++)
                        if (sel_addr[i]) m.slv = i;
                end else begin
                    m.err_left = 2;
                end
            end
        end else begin
            m.stall++;
            if (tmo > 0 && m.stall == tmo) begin
                m.slv      = -1;
                m.err_left = 2;
                m.irq      = 1'b1;
                m.stall    = 0;
            end
        end
    endtask

    task automatic check_dut(input string p, input mdl_t m, input logic rdy_g, input logic [RW-1:0] rsp_g,
                             input logic [DW-1:0] dat_g, input logic [CH-1:0] sel_g, input logic irq_g);
        logic          rdy;
        logic [RW-1:0] rsp;
        logic [DW-1:0] dat;
        logic [CH-1:0] sel;
        mdl_out(m, rdy, rsp, dat, sel);
        chk({p, "_hready"}, rdy_g, rdy);
        chk({p, "_hresp"}, rsp_g, rsp);
        chk({p, "_hrdata"}, dat_g, dat);
        chk({p, "_hsel_data"}, sel_g, sel);
        chk({p, "_irq"}, irq_g, m.irq);
    endtask

    // Entered and left at posedge+1 with the cycle's inputs already applied.
    task automatic cycle();
        @(negedge HCLK);
        check_dut("wd", ma, a_hready_out, a_hresp_out, a_hrdata_out, a_hsel_data, a_timeout_irq);
        check_dut("nowd", mb, b_hready_out, b_hresp_out, b_hrdata_out, b_hsel_data, b_timeout_irq);
        mdl_step(ma, 8);
        mdl_step(mb, 0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_idle();
        htrans       = 2'b00;
        sel_addr     = '0;
        hreadyout_in = '1;
        hresp_in     = '0;
        for (int i = 0; i < CH; i++) hrdata_in[i*DW +: DW] = $urandom;
    endtask

    task automatic rand_in(input bit stall);
        int r;
        htrans = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 9);
        if (r < 8)       sel_addr = CH'(1) << $urandom_range(0, CH-1);
        else if (r == 8) sel_addr = '0;
        else             sel_addr = CH'($urandom);
        for (int i = 0; i < CH; i++) begin
            hreadyout_in[i]       = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            hresp_in[i*RW +: RW]  = RW'($urandom_range(0, 7) == 0);
            hrdata_in[i*DW +: DW] = $urandom;
        end
    endtask

    task automatic check_async_reset();
        chk("rst_wd_hready", a_hready_out, 1'b1);
        chk("rst_wd_hresp", a_hresp_out, '0);
        chk("rst_wd_hrdata", a_hrdata_out, '0);
        chk("rst_wd_hsel", a_hsel_data, '0);
        chk("rst_wd_irq", a_timeout_irq, 1'b0);
        chk("rst_nowd_hready", b_hready_out, 1'b1);
        chk("rst_nowd_hsel", b_hsel_data, '0);
        chk("rst_nowd_irq", b_timeout_irq, 1'b0);
    endtask

    task automatic unmapped(input logic [CH-1:0] bad_sel);
        htrans = 2'b10; sel_addr = bad_sel;
        cycle();
        htrans = 2'b00; sel_addr = '0;
        #1;
        chk("unmap_err1_hready", a_hready_out, 1'b0);
        chk("unmap_err1_hresp", a_hresp_out, 1'b1);
        cycle();
        #1;
        chk("unmap_err2_hready", a_hready_out, 1'b1);
        chk("unmap_err2_hresp", a_hresp_out, 1'b1);
        cycle();
        #1;
        chk("unmap_done_hresp", a_hresp_out, 1'b0);
        cycle();
    endtask

    initial begin
        int burst;
        HRESETn = 1'b0;
        set_idle();
        ma = MDL_RST;
        mb = MDL_RST;
        #1;
        check_async_reset();
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        repeat (2) cycle();

        // Pipelined reads ch1 then ch2 with the decoder moving on during ch1's data phase.
        hrdata_in[1*DW +: DW] = 32'hA5A5_0001;
        hrdata_in[2*DW +: DW] = 32'h5A5A_0002;
        htrans = 2'b10; sel_addr = 4'b0010;
        cycle();
        sel_addr = 4'b0100;
        #1;
        chk("pipe_ch1_data", a_hrdata_out, 32'hA5A5_0001);
        chk("pipe_ch1_sel", a_hsel_data, 4'b0010);
        cycle();
        htrans = 2'b00; sel_addr = '0;
        #1;
        chk("pipe_ch2_data", a_hrdata_out, 32'h5A5A_0002);
        chk("pipe_ch2_ready", a_hready_out, 1'b1);
        cycle();

        // Three wait states on ch3, data on the fourth cycle.
        htrans = 2'b10; sel_addr = 4'b1000;
        cycle();
        htrans = 2'b00; sel_addr = '0; hreadyout_in[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_hready", a_hready_out, 1'b0);
            cycle();
        end
        hreadyout_in[3] = 1'b1;
        hrdata_in[3*DW +: DW] = 32'hC0DE_0003;
        #1;
        chk("wait_data", a_hrdata_out, 32'hC0DE_0003);
        chk("wait_irq", a_timeout_irq, 1'b0);
        cycle();

        unmapped(4'b0000);
        unmapped(4'b0011);

        // Watchdog: ch0 never responds.
        htrans = 2'b10; sel_addr = 4'b0001;
        cycle();
        htrans = 2'b00; sel_addr = '0; hreadyout_in[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("wd_stall_irq", a_timeout_irq, 1'b0);
            cycle();
        end
        #1;
        chk("wd_err1_irq", a_timeout_irq, 1'b1);
        chk("wd_err1_hready", a_hready_out, 1'b0);
        chk("wd_err1_hresp", a_hresp_out, 1'b1);
        cycle();
        #1;
        chk("wd_err2_irq", a_timeout_irq, 1'b0);
        chk("wd_err2_hready", a_hready_out, 1'b1);
        chk("wd_err2_hresp", a_hresp_out, 1'b1);
        cycle();
        set_idle();
        cycle();

        // IDLE and BUSY give idle outputs, then a NONSEQ.
        htrans = 2'b00; sel_addr = 4'b0001;
        cycle();
        htrans = 2'b01; sel_addr = 4'b0010;
        #1;
        chk("idle_hsel", a_hsel_data, '0);
        cycle();
        htrans = 2'b10; sel_addr = 4'b0100;
        #1;
        chk("busy_hsel", a_hsel_data, '0);
        chk("busy_hrdata", a_hrdata_out, '0);
        cycle();

        // Long stall: the disabled-watchdog instance must never abort.
        htrans = 2'b00; sel_addr = '0; hreadyout_in = '0;
        for (int i = 0; i < 1000; i++) cycle();
        #1;
        chk("nowd_long_hready", b_hready_out, 1'b0);
        chk("nowd_long_hsel", b_hsel_data, 4'b0100);
        set_idle();
        cycle();

        // Reset in the middle of a stalled data phase.
        htrans = 2'b10; sel_addr = 4'b0010;
        cycle();
        htrans = 2'b00; sel_addr = '0; hreadyout_in = '0;
        cycle();
        cycle();
        #2;
        HRESETn = 1'b0;
        #1;
        check_async_reset();
        ma = MDL_RST;
        mb = MDL_RST;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        set_idle();
        cycle();

        // Randomized traffic with occasional long stall bursts.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(5, 14);
            rand_in(burst != 0);
            if (burst > 0) burst--;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_resp_mux.md
# ahb_resp_mux

Parametrised per-master AHB response multiplexer, successor to the one-hot combinational master-side mux. It captures the decoder's one-hot slave select in the address phase and holds it through the data phase, so HRDATA/HREADY/HRESP from the correct slave are returned to the master even while the decoder moves on to the next address. It sits between the slave response buses and one master port of the interconnect. It adds two in-block error sources:

- a built-in default-slave ERROR response for unmapped or multi-hot selects;
- a stall watchdog that terminates hung transfers.

## Interface
Parameters:
- CHANNEL_NUM, 4, number of slave channels
- DATA_WIDTH, 32, HRDATA width
- RESP_WIDTH, 1, HRESP width (1 = AHB-Lite, 2 = AHB2; ERROR encoding is 1 in both)
- TIMEOUT, 256, stall cycles before watchdog abort; 0 disables the watchdog
- CNT_WIDTH, 9, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT

Ports:
- HCLK  in  1  clock, all state updates on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- sel_addr  in  CHANNEL_NUM  one-hot decoder select for the current address phase
- htrans  in  2  master HTRANS (bit 1 set = NONSEQ/SEQ)
- hrdata_in  in  CHANNEL_NUM x DATA_WIDTH  per-slave HRDATA
- hreadyout_in  in  CHANNEL_NUM  per-slave HREADYOUT
- hresp_in  in  CHANNEL_NUM x RESP_WIDTH  per-slave HRESP
- hrdata_out  out  DATA_WIDTH  to master
- hready_out  out  1  to master and fed back as HREADY to all slaves
- hresp_out  out  RESP_WIDTH  to master
- hsel_data  out  CHANNEL_NUM  registered data-phase select
- timeout_irq  out  1  one-cycle pulse on watchdog abort

## Operation
An address phase is accepted on a rising edge where hready_out = 1.

State machine states: D_IDLE, D_SLAVE, DEF_ERR1, DEF_ERR2, TO_ERR1, TO_ERR2.

Transitions at acceptance (from D_IDLE, D_SLAVE with selected HREADYOUT = 1, DEF_ERR2, TO_ERR2):
- htrans[1] = 0 -> D_IDLE, hsel_data = 0
- htrans[1] = 1 and sel_addr exactly one-hot -> D_SLAVE, hsel_data = sel_addr
- htrans[1] = 1 and sel_addr zero or multi-hot -> DEF_ERR1, hsel_data = 0

Other transitions:
- DEF_ERR1 -> DEF_ERR2 unconditionally
- TO_ERR1 -> TO_ERR2 unconditionally

Outputs by state:
- D_IDLE: hready_out = 1, hresp_out = 0, hrdata_out = 0
- D_SLAVE: combinational pass-through of channel hsel_data (HRDATA, HREADYOUT, HRESP); no added latency
- DEF_ERR1 / TO_ERR1: hready_out = 0, hresp_out = 1, hrdata_out = 0
- DEF_ERR2 / TO_ERR2: hready_out = 1, hresp_out = 1, hrdata_out = 0

Watchdog (TIMEOUT > 0):
- The counter increments each cycle in D_SLAVE with the selected HREADYOUT = 0.
- It clears on any other cycle.
- When the counter equals TIMEOUT-1 and the selected HREADYOUT is still 0, the next state is TO_ERR1, hsel_data clears and timeout_irq pulses.
- After the abort, the slave's late response is ignored.

Boundary conditions:
- Address acceptance is blocked in DEF_ERR1/TO_ERR1 because hready_out = 0 there.
- If the master does not cancel with IDLE during ERR2, the new address phase is accepted normally.
- A slave that signals its own 2-cycle ERROR is passed through unmodified; it is not treated as a timeout.
- Reset asserted mid-transfer returns all state to reset values immediately, regardless of phase.

## Timing
- Reset values:
  - state D_IDLE, hsel_data 0, counter 0
  - hready_out 1, hresp_out 0, hrdata_out 0, timeout_irq 0
- Select capture: sel_addr sampled at acceptance edge; visible on hsel_data in the next cycle (data phase).
- Data path latency: 0 cycles from hreadyout_in/hrdata_in/hresp_in to outputs in D_SLAVE.
- Default-slave error: 2 cycles, first with hready_out low.
- Watchdog: abort on the edge after TIMEOUT consecutive stall cycles. timeout_irq is registered and high for exactly the TO_ERR1 cycle.
- Back-to-back transfers to different slaves need no bubble; hsel_data switches on each accepting edge.

## Test plan
- Reset: HRESETn low mid D_SLAVE stall -> hready_out = 1, hresp_out = 0, hsel_data = 0, timeout_irq = 0 asynchronously.
- Pipelined read: NONSEQ to ch1 then ch2; sel_addr changes to 4'b0100 during the ch1 data phase -> hrdata_out returns ch1 data (0xA5A5_0001), then ch2 data (0x5A5A_0002) on the next cycle, with no bubble.
- Wait states: ch3 HREADYOUT low for 3 cycles -> hready_out low for 3 cycles; data is returned on the 4th cycle; timeout_irq stays 0.
- Unmapped: NONSEQ with sel_addr = 0 and, separately, 4'b0011 -> hresp_out = 1 for 2 cycles, hready_out pattern 0 then 1.
- Watchdog: TIMEOUT = 8, ch0 HREADYOUT held low -> 8 stall cycles, then TO_ERR1 with timeout_irq = 1 for 1 cycle, then TO_ERR2 with hready_out = 1.
- Mixed: IDLE, BUSY, then NONSEQ -> D_IDLE outputs for the IDLE/BUSY transfers; watchdog disabled (TIMEOUT = 0) never aborts a 1000-cycle stall.
